// File: rtl/sound_frame_seq_if.sv
// Control and event bundle between the APU register block / channels and the frame sequencer.
interface sound_frame_seq_if;
    logic       sound_en;
    logic [3:0] trig;
    logic [2:0] step;
    logic       length_tick;
    logic       sweep_tick;
    logic       env_tick;
    logic       clk_length_ctr;
    logic       clk_sweep;
    logic       clk_vol_env;
    logic [3:0] start;

    modport master (
        output sound_en, trig,
        input  step, length_tick, sweep_tick, env_tick,
        input  clk_length_ctr, clk_sweep, clk_vol_env, start
    );

    modport slave (
        input  sound_en, trig,
        output step, length_tick, sweep_tick, env_tick,
        output clk_length_ctr, clk_sweep, clk_vol_env, start
    );
endinterface

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 512 Hz 8-step sequence producing length/sweep/envelope strobes and
// level clocks, plus fixed-width per-channel start pulses from NRx4 trigger writes.
module sound_frame_seq #(
    parameter int CLK_DIV = 8192,
    parameter int START_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    sound_frame_seq_if.slave  bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(START_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(START_W);

    logic [DIV_W-1:0]            div_q, div_d;
    logic [2:0]                  step_q, step_d;
    logic                        len_tick_q, len_tick_d;
    logic                        sweep_tick_q, sweep_tick_d;
    logic                        env_tick_q, env_tick_d;
    logic                        clk_len_q, clk_len_d;
    logic                        clk_sweep_q, clk_sweep_d;
    logic                        clk_env_q, clk_env_d;
    logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]                  start_q, start_d;
    logic                        term_s;

    assign term_s = (div_q == DIV_LAST);

    // Next-state: prescaler, step, strobes from the old step, level clocks and start counters.
    always_comb begin
        div_d        = div_q;
        step_d       = step_q;
        len_tick_d   = 1'b0;
        sweep_tick_d = 1'b0;
        env_tick_d   = 1'b0;
        clk_len_d    = 1'b0;
        clk_sweep_d  = 1'b0;
        clk_env_d    = 1'b0;
        cnt_d        = cnt_q;
        start_d      = 4'b0000;
        if (!bus.sound_en) begin
            div_d  = '0;
            step_d = 3'd0;
            cnt_d  = '0;
        end else begin
            if (term_s) begin
                div_d  = '0;
                step_d = step_q + 3'd1;
            end else begin
                div_d  = div_q + DIV_W'(1);
            end
            len_tick_d   = term_s & ~step_q[0];
            sweep_tick_d = term_s & ((step_q == 3'd2) | (step_q == 3'd6));
            env_tick_d   = term_s & (step_q == 3'd7);
            // Level clocks drop half a step after rising; events never overlap.
            if (len_tick_d) begin
                clk_len_d = 1'b1;
            end else if (div_d == DIV_HALF) begin
                clk_len_d = 1'b0;
            end else begin
                clk_len_d = clk_len_q;
            end
            if (sweep_tick_d) begin
                clk_sweep_d = 1'b1;
            end else if (div_d == DIV_HALF) begin
                clk_sweep_d = 1'b0;
            end else begin
                clk_sweep_d = clk_sweep_q;
            end
            if (env_tick_d) begin
                clk_env_d = 1'b1;
            end else if (div_d == DIV_HALF) begin
                clk_env_d = 1'b0;
            end else begin
                clk_env_d = clk_env_q;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.trig[i]) begin
                    cnt_d[i] = CNT_LOAD;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            start_d[i] = (cnt_d[i] != '0);
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            step_q       <= 3'd0;
            len_tick_q   <= 1'b0;
            sweep_tick_q <= 1'b0;
            env_tick_q   <= 1'b0;
            clk_len_q    <= 1'b0;
            clk_sweep_q  <= 1'b0;
            clk_env_q    <= 1'b0;
            cnt_q        <= '0;
            start_q      <= 4'b0000;
        end else begin
            div_q        <= div_d;
            step_q       <= step_d;
            len_tick_q   <= len_tick_d;
            sweep_tick_q <= sweep_tick_d;
            env_tick_q   <= env_tick_d;
            clk_len_q    <= clk_len_d;
            clk_sweep_q  <= clk_sweep_d;
            clk_env_q    <= clk_env_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
        end
    end

    assign bus.step           = step_q;
    assign bus.length_tick    = len_tick_q;
    assign bus.sweep_tick     = sweep_tick_q;
    assign bus.env_tick       = env_tick_q;
    assign bus.clk_length_ctr = clk_len_q;
    assign bus.clk_sweep      = clk_sweep_q;
    assign bus.clk_vol_env    = clk_env_q;
    assign bus.start          = start_q;
endmodule
